memory_bus_responder: RTL and testbench

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

---
 rtl/memory_bus_responder.sv | 172 +++++++++++++++++
 tb/tb_memory_bus_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_responder.sv
// Memory bus write responder: qualifies EN/WE writes and fans them out to region strobes.
// Optional committed-write counter enabled by defining MEMORY_BUS_WR_COUNTER_EN.
module memory_bus_responder #(
    parameter int unsigned WR_HOLD = 2
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        WE,
    input  logic [1:0]  BRAM_SELECT,
    input  logic [13:0] BRAM_ADDR,
    input  logic [15:0] DATA_IN,
    output logic        CTL_WE,
    output logic [7:0]  CTL_ADDR,
    output logic        MOD_WE,
    output logic [14:0] MOD_ADDR,
    output logic        PWE_WE,
    output logic [7:0]  PWE_ADDR,
    output logic        STM_WE,
    output logic [18:0] STM_ADDR,
    output logic [15:0] WDATA,
    output logic [31:0] WR_CNT
);

    localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'd0;
    localparam logic [1:0] BRAM_SELECT_MOD        = 2'd1;
    localparam logic [1:0] BRAM_SELECT_PWE_TABLE  = 2'd2;
    localparam logic [1:0] BRAM_SELECT_STM        = 2'd3;

    localparam logic [7:0] ADDR_MOD_MEM_WR_SEGMENT = 8'h10;
    localparam logic [7:0] ADDR_STM_MEM_WR_SEGMENT = 8'h11;
    localparam logic [7:0] ADDR_STM_MEM_WR_PAGE    = 8'h12;

    // A hold of zero cycles makes no sense; treat it as one.
    localparam int unsigned HOLD_MIN = (WR_HOLD < 1) ? 1 : WR_HOLD;
    localparam int CW = $clog2(HOLD_MIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        COMMIT,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          capture;
    logic          commit;
    logic          bus_wr;

    logic [1:0]    cap_sel;
    logic [13:0]   cap_addr;
    logic [15:0]   cap_data;
    logic          mod_segment;
    logic          stm_segment;
    logic [3:0]    stm_page;
    logic          ctl_hit;

    assign bus_wr  = EN & WE;
    assign ctl_hit = commit && (cap_sel == BRAM_SELECT_CONTROLLER);

    // State and hold-counter register.
    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; cnt counts EN&WE-high samples including the entry one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus_wr) begin
                    state_nx = HOLD;
                    cnt_nx   = CW'(1);
                    capture  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(HOLD_MIN)) begin
                    state_nx = COMMIT;
                end else if (!bus_wr) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (!WE) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the bus transaction at HOLD entry; later DATA_IN changes are ignored.
    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            cap_sel  <= '0;
            cap_addr <= '0;
            cap_data <= '0;
        end else if (capture) begin
            cap_sel  <= BRAM_SELECT;
            cap_addr <= BRAM_ADDR;
            cap_data <= DATA_IN;
        end
    end

    // Segment/page registers update as the controller commit ends, so they
    // only steer later MOD/STM commits.
    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            mod_segment <= 1'b0;
            stm_segment <= 1'b0;
            stm_page    <= 4'd0;
        end else if (ctl_hit) begin
            if (cap_addr[7:0] == ADDR_MOD_MEM_WR_SEGMENT) begin
                mod_segment <= cap_data[0];
            end
            if (cap_addr[7:0] == ADDR_STM_MEM_WR_SEGMENT) begin
                stm_segment <= cap_data[0];
            end
            if (cap_addr[7:0] == ADDR_STM_MEM_WR_PAGE) begin
                stm_page <= cap_data[3:0];
            end
        end
    end

    assign CTL_WE   = ctl_hit;
    assign MOD_WE   = commit && (cap_sel == BRAM_SELECT_MOD);
    assign PWE_WE   = commit && (cap_sel == BRAM_SELECT_PWE_TABLE);
    assign STM_WE   = commit && (cap_sel == BRAM_SELECT_STM);

    assign CTL_ADDR = cap_addr[7:0];
    assign PWE_ADDR = cap_addr[7:0];
    assign MOD_ADDR = {mod_segment, cap_addr};
    assign STM_ADDR = {stm_segment, stm_page, cap_addr};
    assign WDATA    = cap_data;

`ifdef MEMORY_BUS_WR_COUNTER_EN
    logic [31:0] wr_cnt;

    // Committed-write counter, wraps naturally at 32 bits.
    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            wr_cnt <= '0;
        end else if (commit) begin
            wr_cnt <= wr_cnt + 32'd1;
        end
    end

    assign WR_CNT = wr_cnt;
`else
    assign WR_CNT = '0;
`endif

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder: table of writes plus reset corner sequences.
module tb_memory_bus_responder;

    localparam logic [1:0] S_CTL = 2'd0;
    localparam logic [1:0] S_MOD = 2'd1;
    localparam logic [1:0] S_PWE = 2'd2;
    localparam logic [1:0] S_STM = 2'd3;
    localparam int LAT = 2;

    logic        BUS_CLK;
    logic        RST;
    logic        EN;
    logic        WE;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] BRAM_ADDR;
    logic [15:0] DATA_IN;
    logic        CTL_WE;
    logic [7:0]  CTL_ADDR;
    logic        MOD_WE;
    logic [14:0] MOD_ADDR;
    logic        PWE_WE;
    logic [7:0]  PWE_ADDR;
    logic        STM_WE;
    logic [18:0] STM_ADDR;
    logic [15:0] WDATA;
    logic [31:0] WR_CNT;

    memory_bus_responder #(.WR_HOLD(2)) dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .EN(EN), .WE(WE),
        .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR),
        .DATA_IN(DATA_IN),
        .CTL_WE(CTL_WE), .CTL_ADDR(CTL_ADDR),
        .MOD_WE(MOD_WE), .MOD_ADDR(MOD_ADDR),
        .PWE_WE(PWE_WE), .PWE_ADDR(PWE_ADDR),
        .STM_WE(STM_WE), .STM_ADDR(STM_ADDR),
        .WDATA(WDATA), .WR_CNT(WR_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int n_str[4] = '{0, 0, 0, 0};
    int n_multi = 0;
    int last_cyc = 0;
    logic [18:0] last_addr = '0;
    logic [15:0] last_wdata = '0;

    int d_str[4];
    int d_tot;
    int t0;

    always @(posedge BUS_CLK) cyc++;

    // Record every strobe seen, away from the active edge.
    always @(negedge BUS_CLK) begin
        int k;
        k = int'(CTL_WE) + int'(MOD_WE) + int'(PWE_WE) + int'(STM_WE);
        if (k > 1) n_multi++;
        if (CTL_WE) begin n_str[0]++; last_addr = {11'd0, CTL_ADDR}; end
        if (MOD_WE) begin n_str[1]++; last_addr = {4'd0, MOD_ADDR}; end
        if (PWE_WE) begin n_str[2]++; last_addr = {11'd0, PWE_ADDR}; end
        if (STM_WE) begin n_str[3]++; last_addr = STM_ADDR; end
        if (k > 0) begin
            last_wdata = WDATA;
            last_cyc   = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) d_str[i] = n_str[i];
    endtask

    task automatic delta();
        d_tot = 0;
        for (int i = 0; i < 4; i++) begin
            d_str[i] = n_str[i] - d_str[i];
            d_tot += d_str[i];
        end
    endtask

    task automatic run_op(input logic [1:0] s, input logic [13:0] a,
                          input logic [15:0] d, input int h);
        @(negedge BUS_CLK);
        snap();
        t0 = cyc;
        EN = 1'b1;
        WE = 1'b1;
        BRAM_SELECT = s;
        BRAM_ADDR = a;
        DATA_IN = d;
        for (int i = 0; i < h; i++) begin
            @(negedge BUS_CLK);
            DATA_IN = ~d;
        end
        EN = 1'b0;
        WE = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        delta();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] data;
        int          hold;
        int          kind;
        logic [18:0] eaddr;
    } vec_t;

    vec_t tv[18];

    initial begin
        tv[0]  = '{S_CTL, 14'h0005, 16'hBEEF, 2, 0, 19'h00005};
        tv[1]  = '{S_CTL, 14'h0011, 16'h0001, 2, 0, 19'h00011};
        tv[2]  = '{S_CTL, 14'h0012, 16'h0003, 2, 0, 19'h00012};
        tv[3]  = '{S_STM, 14'h0010, 16'hAAAA, 2, 3, 19'h4C010};
        tv[4]  = '{S_CTL, 14'h0010, 16'h0001, 2, 0, 19'h00010};
        tv[5]  = '{S_MOD, 14'h0123, 16'h1234, 2, 1, 19'h04123};
        tv[6]  = '{S_PWE, 14'h03AB, 16'h5555, 2, 2, 19'h000AB};
        tv[7]  = '{S_CTL, 14'h1F05, 16'h0042, 2, 0, 19'h00005};
        tv[8]  = '{S_CTL, 14'h0012, 16'h000F, 2, 0, 19'h00012};
        tv[9]  = '{S_STM, 14'h0001, 16'h0F0F, 2, 3, 19'h7C001};
        tv[10] = '{S_CTL, 14'h0012, 16'h0000, 2, 0, 19'h00012};
        tv[11] = '{S_STM, 14'h3FFF, 16'h0000, 2, 3, 19'h43FFF};
        tv[12] = '{S_PWE, 14'h0001, 16'h9999, 1, 4, 19'h00000};
        tv[13] = '{S_CTL, 14'h0007, 16'h0707, 10, 0, 19'h00007};
        tv[14] = '{S_CTL, 14'h0011, 16'hFFFE, 2, 0, 19'h00011};
        tv[15] = '{S_STM, 14'h0002, 16'h2222, 2, 3, 19'h00002};
        tv[16] = '{S_CTL, 14'h0010, 16'h0002, 2, 0, 19'h00010};
        tv[17] = '{S_MOD, 14'h3FFF, 16'h0001, 2, 1, 19'h03FFF};

        RST = 1'b1;
        EN = 1'b0;
        WE = 1'b0;
        BRAM_SELECT = '0;
        BRAM_ADDR = '0;
        DATA_IN = '0;
        repeat (3) @(negedge BUS_CLK);
        check("reset_strobes", {28'd0, CTL_WE, MOD_WE, PWE_WE, STM_WE}, 32'd0);
        check("reset_stm_addr", {13'd0, STM_ADDR}, 32'd0);
        check("reset_mod_addr", {17'd0, MOD_ADDR}, 32'd0);
        check("reset_wdata", {16'd0, WDATA}, 32'd0);
        check("reset_wr_cnt", WR_CNT, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge BUS_CLK);

        for (int i = 0; i < 18; i++) begin
            run_op(tv[i].sel, tv[i].addr, tv[i].data, tv[i].hold);
            check($sformatf("v%0d_strobes", i), d_tot,
                  (tv[i].kind == 4) ? 32'd0 : 32'd1);
            if (tv[i].kind != 4) begin
                check($sformatf("v%0d_region", i), d_str[tv[i].kind], 32'd1);
                check($sformatf("v%0d_addr", i), {13'd0, last_addr},
                      {13'd0, tv[i].eaddr});
                check($sformatf("v%0d_wdata", i), {16'd0, last_wdata},
                      {16'd0, tv[i].data});
                check($sformatf("v%0d_latency", i), last_cyc - (t0 + 1), LAT);
            end
        end

        // Reset in the middle of a PWE hold discards it and clears segments.
        @(negedge BUS_CLK);
        snap();
        EN = 1'b1;
        WE = 1'b1;
        BRAM_SELECT = S_PWE;
        BRAM_ADDR = 14'h0055;
        DATA_IN = 16'h7777;
        @(negedge BUS_CLK);
        RST = 1'b1;
        EN = 1'b0;
        WE = 1'b0;
        @(negedge BUS_CLK);
        check("rst_hold_outputs",
              {28'd0, CTL_WE, MOD_WE, PWE_WE, STM_WE}, 32'd0);
        check("rst_hold_wdata", {16'd0, WDATA}, 32'd0);
        RST = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        delta();
        check("rst_hold_no_strobe", d_tot, 32'd0);
        run_op(S_STM, 14'h0010, 16'h1111, 2);
        check("post_rst_stm_addr", {13'd0, last_addr}, 32'h00010);
        check("post_rst_stm_strobe", d_str[3], 32'd1);
        run_op(S_MOD, 14'h0123, 16'h2345, 2);
        check("post_rst_mod_addr", {13'd0, last_addr}, 32'h00123);

        // EN&WE already high when reset releases: full hold still needed.
        @(negedge BUS_CLK);
        RST = 1'b1;
        EN = 1'b1;
        WE = 1'b1;
        BRAM_SELECT = S_CTL;
        BRAM_ADDR = 14'h0009;
        DATA_IN = 16'h0909;
        @(negedge BUS_CLK);
        snap();
        RST = 1'b0;
        t0 = cyc;
        repeat (2) @(negedge BUS_CLK);
        EN = 1'b0;
        WE = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        delta();
        check("rst_rel_strobes", d_tot, 32'd1);
        check("rst_rel_ctl", d_str[0], 32'd1);
        check("rst_rel_latency", last_cyc - (t0 + 1), LAT);
        check("rst_rel_addr", {13'd0, last_addr}, 32'h00009);

        // 256 back-to-back PWE writes from a clean reset.
        @(negedge BUS_CLK);
        RST = 1'b1;
        @(negedge BUS_CLK);
        RST = 1'b0;
        snap();
        for (int i = 0; i < 256; i++) begin
            EN = 1'b1;
            WE = 1'b1;
            BRAM_SELECT = S_PWE;
            BRAM_ADDR = 14'(i);
            DATA_IN = 16'(i);
            repeat (2) @(negedge BUS_CLK);
            EN = 1'b0;
            WE = 1'b0;
            repeat (4) @(negedge BUS_CLK);
        end
        delta();
        check("burst_pwe_strobes", d_str[2], 32'd256);
        check("burst_total", d_tot, 32'd256);
`ifdef MEMORY_BUS_WR_COUNTER_EN
        check("burst_wr_cnt", WR_CNT, 32'd256);
`else
        check("burst_wr_cnt", WR_CNT, 32'd0);
`endif
        check("never_multi_strobe", n_multi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
